// File: rtl/mesh_router_node_if.sv
// Handshake bundle for one mesh_router_node: five input flit channels and five
// output flit channels, flattened with port p at [p*WIDTH +: WIDTH]
// (0 = self, 1 = west, 2 = east, 3 = north, 4 = south).
interface mesh_router_node_if #(
    parameter int WIDTH = 32
);
    // Valid/ready: a flit transfers on a rising clock edge where valid and
    // ready are both high. A producer that raises valid keeps valid and data
    // stable until that transfer; ready may change freely and never depends
    // on anything except the consumer's own registered state (and reset).
    logic [5*WIDTH-1:0] in_data;
    logic [4:0]         in_valid;
    logic [4:0]         in_ready;
    logic [5*WIDTH-1:0] out_data;
    logic [4:0]         out_valid;
    logic [4:0]         out_ready;

    // Environment side: drives incoming flits and downstream ready.
    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    // Router side.
    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/mesh_router_node.sv
// 2D mesh router node: five buffered input ports, X-then-Y routing of each
// FIFO head, and a round-robin arbiter feeding a registered slot per output.
// Optional feature macro: MESH_ROUTER_NODE_STATS_EN adds delivered_count,
// a saturating count of flits handed off on the self output.
module mesh_router_node #(
    parameter int WIDTH      = 32,
    parameter int COORD_BITS = 3,
    parameter int NODE_X     = 0,
    parameter int NODE_Y     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    mesh_router_node_if.slave bus
`ifdef MESH_ROUTER_NODE_STATS_EN
    ,
    output logic [15:0] delivered_count
`endif
);
    localparam int NP    = 5;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [COORD_BITS-1:0] MY_X = COORD_BITS'(NODE_X);
    localparam logic [COORD_BITS-1:0] MY_Y = COORD_BITS'(NODE_Y);

    localparam logic [2:0] P_SELF  = 3'd0;
    localparam logic [2:0] P_WEST  = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_NORTH = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    // Input FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem    [NP][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [NP];
    logic [PTR_W-1:0] rd_ptr [NP];
    logic [CNT_W-1:0] count  [NP];
    logic [NP-1:0]    full;
    logic [NP-1:0]    empty;
    logic [NP-1:0]    push;
    logic [NP-1:0]    pop;

    // Routing and arbitration
    logic [WIDTH-1:0] head      [NP];
    logic [2:0]       route     [NP];
    logic [NP-1:0]    req       [NP];   // req[o][p]: head of p wants output o
    logic [NP-1:0]    loadable;
    logic [NP-1:0]    grant_any;
    logic [2:0]       grant_sel [NP];
    logic [2:0]       rr_ptr    [NP];

    // Output slots
    logic [WIDTH-1:0] out_q     [NP];
    logic [NP-1:0]    out_valid_q;

    // FIFO status comes from registered occupancy only, so in_ready never
    // depends on this cycle's pops.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            full[p]  = (count[p] == CNT_W'(FIFO_DEPTH));
            empty[p] = (count[p] == '0);
        end
    end

    assign bus.in_ready = rst_n ? ~full : '0;
    assign push         = bus.in_valid & bus.in_ready;
    assign loadable     = ~out_valid_q | bus.out_ready;

    // X-then-Y route of every FIFO head; empty heads are masked in req.
    always_comb begin
        logic [COORD_BITS-1:0] dx;
        logic [COORD_BITS-1:0] dy;
        dx = '0;
        dy = '0;
        for (int p = 0; p < NP; p++) begin
            head[p] = mem[p][rd_ptr[p]];
            dx      = head[p][WIDTH-1 -: COORD_BITS];
            dy      = head[p][WIDTH-1-COORD_BITS -: COORD_BITS];
            if (dx > MY_X)      route[p] = P_EAST;
            else if (dx < MY_X) route[p] = P_WEST;
            else if (dy > MY_Y) route[p] = P_NORTH;
            else if (dy < MY_Y) route[p] = P_SOUTH;
            else                route[p] = P_SELF;
        end
    end

    // Request matrix: one output per non-empty head.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            for (int p = 0; p < NP; p++) begin
                req[o][p] = !empty[p] && (route[p] == 3'(o));
            end
        end
    end

    // Round-robin grant per loadable output, scanning upward from rr_ptr.
    // A head requests a single output, so each FIFO pops at most once.
    always_comb begin
        int idx;
        idx = 0;
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            grant_any[o] = 1'b0;
            grant_sel[o] = '0;
            if (loadable[o]) begin
                for (int k = 0; k < NP; k++) begin
                    idx = int'(rr_ptr[o]) + k;
                    if (idx >= NP) idx = idx - NP;
                    if (!grant_any[o] && req[o][idx]) begin
                        grant_any[o] = 1'b1;
                        grant_sel[o] = 3'(idx);
                    end
                end
            end
            if (grant_any[o]) pop[grant_sel[o]] = 1'b1;
        end
    end

    // FIFO pointers and occupancy; a push is only possible when not full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + CNT_W'(1);
                    2'b01:   count[p] <= count[p] - CNT_W'(1);
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    // FIFO data array; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= bus.in_data[p*WIDTH +: WIDTH];
        end
    end

    // Output slots and round-robin pointers; a drained slot keeps its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            for (int o = 0; o < NP; o++) begin
                out_q[o]  <= '0;
                rr_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (grant_any[o]) begin
                    out_q[o]       <= head[grant_sel[o]];
                    out_valid_q[o] <= 1'b1;
                    rr_ptr[o]      <= (grant_sel[o] == 3'd4) ? 3'd0 : grant_sel[o] + 3'd1;
                end else if (bus.out_ready[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end

    for (genvar o = 0; o < NP; o++) begin : g_out
        assign bus.out_data[o*WIDTH +: WIDTH] = out_q[o];
    end
    assign bus.out_valid = out_valid_q;

`ifdef MESH_ROUTER_NODE_STATS_EN
    // Saturating count of flits leaving through the self output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delivered_count <= '0;
        end else if (out_valid_q[0] && bus.out_ready[0] && (delivered_count != 16'hFFFF)) begin
            delivered_count <= delivered_count + 16'd1;
        end
    end
`endif

endmodule
